// File: rtl/lmsm_sequencer_if.sv
// Handshake and bus bundle between the multicycle control FSM and the LM/SM sequencer.
// The master side requests sequences and acknowledges transfers; the slave side is the sequencer.
interface lmsm_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic              start;
  logic [7:0]        reg_list;
  logic [ADDR_W-1:0] base_addr;
  logic              ack;
  logic              busy;
  logic              valid;
  logic [2:0]        sel;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        count;
  logic              done;

  modport master (
    output start, reg_list, base_addr, ack,
    input  busy, valid, sel, addr, count, done
  );

  modport slave (
    input  start, reg_list, base_addr, ack,
    output busy, valid, sel, addr, count, done
  );
endinterface

// File: rtl/lmsm_sequencer.sv
// LM/SM register-select sequencer: walks the register bitmap lowest-first, one transfer per ack.
// Latency: start -> first valid in 1 cycle; empty list -> done in 1 cycle; done lasts 1 cycle.
// Backpressure: ack low holds sel/addr/count stable indefinitely; start outside IDLE is dropped.
module lmsm_sequencer #(
  parameter int ADDR_W    = 16,
  parameter int ADDR_STEP = 1
) (
  input  logic                clk,
  input  logic                reset,
  lmsm_sequencer_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_n;
  logic [7:0]        pending_q, pending_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [3:0]        count_q, count_n;
  logic [2:0]        sel_w;
  logic [7:0]        pending_cleared;

  // Lowest set bit wins; scanning high-to-low lets the last hit be the lowest index.
  always_comb begin
    sel_w = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pending_q[i]) begin
        sel_w = 3'(i);
      end
    end
  end

  assign pending_cleared = pending_q & ~(8'd1 << sel_w);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= 8'd0;
      addr_q    <= '0;
      count_q   <= 4'd0;
    end else begin
      state_q   <= state_n;
      pending_q <= pending_n;
      addr_q    <= addr_n;
      count_q   <= count_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    pending_n = pending_q;
    addr_n    = addr_q;
    count_n   = count_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          pending_n = bus.reg_list;
          addr_n    = bus.base_addr;
          count_n   = 4'd0;
          state_n   = (bus.reg_list != 8'd0) ? STEP : DONE;
        end
      end

      STEP: begin
        if (bus.ack) begin
          pending_n = pending_cleared;
          addr_n    = addr_q + ADDR_W'(ADDR_STEP);
          count_n   = count_q + 4'd1;
          if (pending_cleared == 8'd0) begin
            state_n = DONE;
          end
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Every output is a decode of registered state, so reset clears them without a clock edge.
  assign bus.valid = (state_q == STEP);
  assign bus.busy  = (state_q == STEP) || (state_q == DONE);
  assign bus.done  = (state_q == DONE);
  assign bus.sel   = sel_w;
  assign bus.addr  = addr_q;
  assign bus.count = count_q;

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed bench for lmsm_sequencer: hand-computed expectations for sequencing, stalls,
// ignored inputs, asynchronous reset mid-sequence and address wrap.
module tb_lmsm_sequencer;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  lmsm_sequencer_if #(.ADDR_W(16)) bus ();

  lmsm_sequencer #(.ADDR_W(16), .ADDR_STEP(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic b, input logic v, input logic d,
                            input logic [2:0] s, input logic [15:0] a, input logic [3:0] c);
    chk($sformatf("%s.busy", tag),  {31'd0, bus.busy},  {31'd0, b});
    chk($sformatf("%s.valid", tag), {31'd0, bus.valid}, {31'd0, v});
    chk($sformatf("%s.done", tag),  {31'd0, bus.done},  {31'd0, d});
    chk($sformatf("%s.sel", tag),   {29'd0, bus.sel},   {29'd0, s});
    chk($sformatf("%s.addr", tag),  {16'd0, bus.addr},  {16'd0, a});
    chk($sformatf("%s.count", tag), {28'd0, bus.count}, {28'd0, c});
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.reg_list  = 8'h00;
    bus.base_addr = 16'h0000;
    bus.ack       = 1'b0;

    #2;
    expect_out("reset", 0, 0, 0, 3'd0, 16'h0000, 4'd0);
    tick();
    reset = 1'b0;
    tick();
    expect_out("idle", 0, 0, 0, 3'd0, 16'h0000, 4'd0);

    // Normal sequence: 0xA5 from 0x0040 with ack held high.
    bus.start = 1'b1; bus.reg_list = 8'hA5; bus.base_addr = 16'h0040; bus.ack = 1'b1;
    tick();
    bus.start = 1'b0;
    expect_out("norm0", 1, 1, 0, 3'd0, 16'h0040, 4'd0);
    tick(); expect_out("norm1", 1, 1, 0, 3'd2, 16'h0041, 4'd1);
    tick(); expect_out("norm2", 1, 1, 0, 3'd5, 16'h0042, 4'd2);
    tick(); expect_out("norm3", 1, 1, 0, 3'd7, 16'h0043, 4'd3);
    tick(); expect_out("norm_done", 1, 0, 1, 3'd0, 16'h0044, 4'd4);
    tick(); expect_out("norm_idle", 0, 0, 0, 3'd0, 16'h0044, 4'd4);

    // Empty list: done one cycle after start, never valid.
    bus.start = 1'b1; bus.reg_list = 8'h00; bus.base_addr = 16'h1234;
    tick();
    bus.start = 1'b0;
    expect_out("empty_done", 1, 0, 1, 3'd0, 16'h1234, 4'd0);
    tick(); expect_out("empty_idle", 0, 0, 0, 3'd0, 16'h1234, 4'd0);

    // Stall: 0x81 from 0x0100, ack low for three cycles.
    bus.ack = 1'b0;
    bus.start = 1'b1; bus.reg_list = 8'h81; bus.base_addr = 16'h0100;
    tick();
    bus.start = 1'b0;
    expect_out("stall1", 1, 1, 0, 3'd0, 16'h0100, 4'd0);
    tick(); expect_out("stall2", 1, 1, 0, 3'd0, 16'h0100, 4'd0);
    tick(); expect_out("stall3", 1, 1, 0, 3'd0, 16'h0100, 4'd0);
    tick();
    bus.ack = 1'b1;
    expect_out("stall4", 1, 1, 0, 3'd0, 16'h0100, 4'd0);
    tick(); expect_out("stall_r7", 1, 1, 0, 3'd7, 16'h0101, 4'd1);
    tick(); expect_out("stall_done", 1, 0, 1, 3'd0, 16'h0102, 4'd2);
    tick(); expect_out("stall_idle", 0, 0, 0, 3'd0, 16'h0102, 4'd2);

    // Ignored inputs: restart attempt with new list/base during STEP and DONE.
    bus.start = 1'b1; bus.reg_list = 8'h06; bus.base_addr = 16'h0200;
    tick();
    bus.reg_list = 8'hFF; bus.base_addr = 16'h0300;
    expect_out("ign0", 1, 1, 0, 3'd1, 16'h0200, 4'd0);
    tick(); expect_out("ign1", 1, 1, 0, 3'd2, 16'h0201, 4'd1);
    tick(); expect_out("ign_done", 1, 0, 1, 3'd0, 16'h0202, 4'd2);
    bus.start = 1'b0;
    tick(); expect_out("ign_idle", 0, 0, 0, 3'd0, 16'h0202, 4'd2);

    // Reset mid-sequence after three acks: outputs clear before any clock edge.
    bus.start = 1'b1; bus.reg_list = 8'hFF; bus.base_addr = 16'h0010;
    tick();
    bus.start = 1'b0;
    expect_out("rst0", 1, 1, 0, 3'd0, 16'h0010, 4'd0);
    tick(); tick(); tick();
    expect_out("rst3", 1, 1, 0, 3'd3, 16'h0013, 4'd3);
    #2;
    reset = 1'b1;
    #1;
    expect_out("rst_async", 0, 0, 0, 3'd0, 16'h0000, 4'd0);
    tick();
    reset = 1'b0;
    expect_out("rst_held", 0, 0, 0, 3'd0, 16'h0000, 4'd0);
    bus.start = 1'b1; bus.reg_list = 8'h10; bus.base_addr = 16'h0700;
    tick();
    bus.start = 1'b0;
    expect_out("rst_new0", 1, 1, 0, 3'd4, 16'h0700, 4'd0);
    tick(); expect_out("rst_new_done", 1, 0, 1, 3'd0, 16'h0701, 4'd1);
    tick(); expect_out("rst_new_idle", 0, 0, 0, 3'd0, 16'h0701, 4'd1);

    // Address wrap: eight transfers from 0xFFFE.
    bus.start = 1'b1; bus.reg_list = 8'hFF; bus.base_addr = 16'hFFFE;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      expect_out($sformatf("wrap%0d", i), 1, 1, 0, 3'(i), 16'(16'hFFFE + i), 4'(i));
      tick();
    end
    expect_out("wrap_done", 1, 0, 1, 3'd0, 16'h0006, 4'd8);
    tick(); expect_out("wrap_idle", 0, 0, 0, 3'd0, 16'h0006, 4'd8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
